// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file sizes and word/index types
package cpu_pkg;
    localparam int REG_W     = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    typedef logic [REG_W-1:0]     reg_word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - execute-stage write port into the register bank
interface regfile_wb_if #(
    parameter int WIDTH = 16
);
    import cpu_pkg::*;

    logic             wr_en;
    reg_idx_t         wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/regfile_wb_slot.sv
// rtl/regfile_wb_slot.sv - one-deep pending write-back slot (valid/addr/data)
module wb_slot
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  reg_idx_t         wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             slot_valid,
    output reg_idx_t         slot_addr,
    output logic [WIDTH-1:0] slot_data
);
    // addr/data only load on a request; they are don't-care while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
        end else begin
            slot_valid <= wr_en;
            if (wr_en) begin
                slot_addr <= wr_addr;
                slot_data <= wr_data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - 16-entry register bank with registered write-back; REGFILE_FORWARD_EN overlays pending data on reads
module regfile_wb
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    regfile_wb_if.slave      wr,
    input  logic             clr_all,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15,
    output logic             wb_valid,
    output reg_idx_t         wb_addr,
    output logic [CNT_W-1:0] wr_count
);
    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] rd   [NUM_REGS];
    logic [WIDTH-1:0] slot_data;
    logic             slot_valid;
    reg_idx_t         slot_addr;

    wb_slot #(.WIDTH(WIDTH)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr.wr_en),
        .wr_addr    (wr.wr_addr),
        .wr_data    (wr.wr_data),
        .slot_valid (slot_valid),
        .slot_addr  (slot_addr),
        .slot_data  (slot_data)
    );

    // clr_all swallows the commit due this edge, so the counter must not advance
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_count <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (slot_valid) begin
            regs[slot_addr] <= slot_data;
            wr_count        <= wr_count + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_rd
`ifdef REGFILE_FORWARD_EN
        assign rd[k] = (slot_valid && slot_addr == reg_idx_t'(k)) ? slot_data : regs[k];
`else
        assign rd[k] = regs[k];
`endif
    end

    assign r0  = rd[0];
    assign r1  = rd[1];
    assign r2  = rd[2];
    assign r3  = rd[3];
    assign r4  = rd[4];
    assign r5  = rd[5];
    assign r6  = rd[6];
    assign r7  = rd[7];
    assign r8  = rd[8];
    assign r9  = rd[9];
    assign r10 = rd[10];
    assign r11 = rd[11];
    assign r12 = rd[12];
    assign r13 = rd[13];
    assign r14 = rd[14];
    assign r15 = rd[15];

    assign wb_valid = slot_valid;
    assign wb_addr  = slot_addr;
endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed self-checking bench for regfile_wb
module tb_regfile_wb;
    import cpu_pkg::*;

`ifdef REGFILE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_all;
    logic [15:0] rv [16];
    logic        wb_valid;
    reg_idx_t    wb_addr;
    logic [7:0]  wr_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    regfile_wb_if #(.WIDTH(16)) wr ();

    regfile_wb #(.WIDTH(16), .CNT_W(8)) dut (
        .clk (clk), .reset (reset), .wr (wr.slave), .clr_all (clr_all),
        .r0 (rv[0]),   .r1 (rv[1]),   .r2 (rv[2]),   .r3 (rv[3]),
        .r4 (rv[4]),   .r5 (rv[5]),   .r6 (rv[6]),   .r7 (rv[7]),
        .r8 (rv[8]),   .r9 (rv[9]),   .r10 (rv[10]), .r11 (rv[11]),
        .r12 (rv[12]), .r13 (rv[13]), .r14 (rv[14]), .r15 (rv[15]),
        .wb_valid (wb_valid), .wb_addr (wb_addr), .wr_count (wr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] a, input logic [15:0] d);
        wr.wr_en   = en;
        wr.wr_addr = a;
        wr.wr_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 4'd0, 16'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        clr_all = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        step();
        reset = 1'b0;

        // random writes, then reset held two cycles
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'($urandom_range(15)), 16'($urandom));
            step();
        end
        do_reset();
        for (int k = 0; k < 16; k++) check($sformatf("reset_r%0d", k), rv[k], 0);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_count", wr_count, 0);

        // single write r5 = BEEF
        drive(1'b1, 4'd5, 16'hBEEF);
        step();
        drive(1'b0, 4'd0, 16'h0);
        check("single_wb_valid_c1", wb_valid, 1);
        check("single_wb_addr_c1", wb_addr, 5);
        check("single_r5_c1", rv[5], FWD ? 16'hBEEF : 16'h0000);
        check("single_count_c1", wr_count, 0);
        step();
        check("single_r5_c2", rv[5], 16'hBEEF);
        check("single_wb_valid_c2", wb_valid, 0);
        check("single_count_c2", wr_count, 1);
        step();
        check("single_r5_c3", rv[5], 16'hBEEF);

        // back-to-back writes to r3
        drive(1'b1, 4'd3, 16'h0001);
        step();
        check("b2b_r3_a", rv[3], FWD ? 16'h0001 : 16'h0000);
        drive(1'b1, 4'd3, 16'h0002);
        step();
        check("b2b_r3_b", rv[3], FWD ? 16'h0002 : 16'h0001);
        drive(1'b1, 4'd3, 16'h0003);
        step();
        check("b2b_r3_c", rv[3], FWD ? 16'h0003 : 16'h0002);
        drive(1'b0, 4'd0, 16'h0);
        step();
        check("b2b_r3_final", rv[3], 16'h0003);
        check("b2b_count", wr_count, 4);
        for (int k = 0; k < 16; k++)
            if (k != 3) check($sformatf("b2b_other_r%0d", k), rv[k], (k == 5) ? 16'hBEEF : 16'h0);

        // clear colliding with a commit and a new capture
        do_reset();
        drive(1'b1, 4'd7, 16'h1234);
        step();
        check("clr_r7_pre", rv[7], FWD ? 16'h1234 : 16'h0000);
        clr_all = 1'b1;
        drive(1'b1, 4'd9, 16'h5555);
        step();
        clr_all = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        for (int k = 0; k < 16; k++)
            check($sformatf("clr_e1_r%0d", k), rv[k], (FWD && k == 9) ? 16'h5555 : 16'h0);
        check("clr_e1_count", wr_count, 0);
        step();
        check("clr_e2_r9", rv[9], 16'h5555);
        check("clr_e2_r7", rv[7], 16'h0);
        check("clr_e2_count", wr_count, 1);

        // 256 writes: counter wraps, last value per address wins
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 4'(i % 16), 16'(16'h1000 + i));
            step();
        end
        drive(1'b0, 4'd0, 16'h0);
        check("wrap_count_255", wr_count, 8'hFF);
        step();
        check("wrap_count_0", wr_count, 8'h00);
        for (int a = 0; a < 16; a++)
            check($sformatf("wrap_r%0d", a), rv[a], 16'h1000 + 240 + a);

        // reset drops a pending write
        do_reset();
        drive(1'b1, 4'd12, 16'hA5A5);
        step();
        drive(1'b0, 4'd0, 16'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_r12_a", rv[12], 0);
        check("rst_mid_wb_valid", wb_valid, 0);
        step();
        step();
        check("rst_mid_r12_b", rv[12], 0);
        check("rst_mid_count", wr_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
